// File: rtl/vga_pkg.sv
// Shared timing defaults for the 640x480 @ 60 Hz scan path.
// Includes segment-length constants, derived totals and the coordinate width.
package vga_pkg;

  localparam int COORD_W      = 10;
  localparam int DEF_DIV      = 4;
  localparam int DEF_DLY      = 1;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = seg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = seg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_sync_delay.sv
// Pixel-enabled shift register that lines the sync/blank decodes up with
// downstream registered colour; DLY = 0 passes the input straight through.
module sync_delay
  import vga_pkg::*;
#(
  parameter int DLY = DEF_DLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] rst_val,
  input  logic [2:0] d,
  output logic [2:0] q
);

  generate
    if (DLY == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [2:0] stage [DLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) stage[i] <= rst_val;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// Pixel-timing generator: pixel-enable divider, scan counters and sync/blank decodes.
// Define VGA_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt reads 0.
module vga_timing
  import vga_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int DLY      = DEF_DLY
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_clk,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        vblank_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_PRE  = DIV_W'(DIV - 2);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // bit order {video_on, hsync, vsync}
  localparam logic [2:0] DEC_IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL};

  logic [DIV_W-1:0]   div_cnt;
  logic [COORD_W-1:0] x_next, y_next, x_dec, y_dec;
  logic [2:0]         dec, dec_q, dly_q;

  assign pix_clk = (div_cnt == DIV_LAST);

  always_comb begin
    x_next = x + 10'd1;
    y_next = y;
    if (x == H_LAST) begin
      x_next = '0;
      y_next = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  // Decode the coordinate that x/y will hold after this edge, so dec_q is in phase with x/y.
  always_comb begin
    x_dec  = pix_clk ? x_next : x;
    y_dec  = pix_clk ? y_next : y;
    dec[2] = (x_dec < H_ACT) && (y_dec < V_ACT);
    dec[1] = ((x_dec >= HS_FIRST) && (x_dec <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    dec[0] = ((y_dec >= VS_FIRST) && (y_dec <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      x            <= '0;
      y            <= '0;
      dec_q        <= DEC_IDLE;
      vblank_start <= 1'b0;
    end else begin
      div_cnt <= pix_clk ? '0 : div_cnt + 1'b1;
      if (pix_clk) begin
        x <= x_next;
        y <= y_next;
      end
      dec_q        <= dec;
      vblank_start <= (div_cnt == DIV_PRE) && (x == '0) && (y == V_ACT);
    end
  end

  sync_delay #(.DLY(DLY)) u_sync_delay (
    .clk     (clk),
    .rst     (rst),
    .en      (pix_clk),
    .rst_val (DEC_IDLE),
    .d       (dec_q),
    .q       (dly_q)
  );

  assign video_on = dly_q[2];
  assign hsync    = dly_q[1];
  assign vsync    = dly_q[0];

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else if (vblank_start) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance plus a shrunken-timing instance
// (DIV=2, DLY=2) so line, frame and vblank behaviour fit in a short run.
module tb_vga_timing;

  localparam int B_DIV = 2;
  localparam int B_HA = 16, B_HFP = 2, B_HS = 4, B_HBP = 2;
  localparam int B_VA = 12, B_VFP = 2, B_VS = 2, B_VBP = 3;
  localparam int B_DLY = 2;
  localparam int B_FRAME = (B_HA + B_HFP + B_HS + B_HBP) * (B_VA + B_VFP + B_VS + B_VBP) * B_DIV;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pix;
    logic        hs;
    logic        vs;
    logic        vo;
    logic        vb;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic        pix_a, hs_a, vs_a, vo_a, vb_a;
  logic [9:0]  x_a, y_a;
  logic [15:0] frame_a;
  logic        pix_b, hs_b, vs_b, vo_b, vb_b;
  logic [9:0]  x_b, y_b;
  logic [15:0] frame_b;

  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_a = 1, n_b = 1;
  logic [15:0] fc_exp_a = '0, fc_exp_b = '0;

  vga_timing dut_a (
    .clk(clk), .rst(rst_a), .pix_clk(pix_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .vblank_start(vb_a), .frame_cnt(frame_a)
  );

  vga_timing #(
    .DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SYNC_POL(1'b0), .DLY(B_DLY)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_clk(pix_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .vblank_start(vb_b), .frame_cnt(frame_b)
  );

  always #5 clk = ~clk;

  // Expected outputs in the cycle n clocks after reset release (n = 0 is the reset state).
  function automatic exp_t model(input int n, input int div, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va, input int vfp,
                                 input int vsw, input int vbp, input int dly);
    exp_t e;
    int ht, vt, p, q, qx, qy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p = n / div;
    e.x   = 10'(p % ht);
    e.y   = 10'((p / ht) % vt);
    e.pix = ((n % div) == div - 1);
    e.vb  = e.pix && ((p % ht) == 0) && (((p / ht) % vt) == va);
    e.fc  = '0;
    if (dly == 0) q = (n == 0) ? -1 : p;
    else          q = (p < dly) ? -1 : p - dly;
    if (q < 0) begin
      e.vo = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      qx = q % ht;
      qy = (q / ht) % vt;
      e.vo = (qx < ha) && (qy < va);
      e.hs = !((qx >= ha + hfp) && (qx < ha + hfp + hsw));
      e.vs = !((qy >= va + vfp) && (qy < va + vfp + vsw));
    end
    return e;
  endfunction

  // Scoreboard producer: predict the state each edge leaves behind.
  always @(posedge clk) begin
    exp_t ea, eb;
    if (rst_a) begin
      ea = model(0, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1);
      fc_exp_a = '0;
      n_a = 1;
    end else begin
      ea = model(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1);
      ea.fc = fc_exp_a;
      n_a++;
`ifdef VGA_FRAME_CNT_EN
      if (ea.vb) fc_exp_a++;
`endif
    end
    if (rst_b) begin
      eb = model(0, B_DIV, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_DLY);
      fc_exp_b = '0;
      n_b = 1;
    end else begin
      eb = model(n_b, B_DIV, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_DLY);
      eb.fc = fc_exp_b;
      n_b++;
`ifdef VGA_FRAME_CNT_EN
      if (eb.vb) fc_exp_b++;
`endif
    end
    q_a.push_back(ea);
    q_b.push_back(eb);
  end

  // Scoreboard consumer: compare on the falling edge, away from the update edge.
  always @(negedge clk) begin
    exp_t act, exp;
    if (q_a.size() > 0) begin
      exp = q_a.pop_front();
      act = '{x: x_a, y: y_a, pix: pix_a, hs: hs_a, vs: vs_a, vo: vo_a, vb: vb_a, fc: frame_a};
      checks++;
      if (act !== exp) begin
        errors++;
        if (errors <= 20)
          $display("[TB] FAIL scoreboard_a t=%0t got x=%0d y=%0d pix=%b hs=%b vs=%b vo=%b vb=%b fc=%0d expected x=%0d y=%0d pix=%b hs=%b vs=%b vo=%b vb=%b fc=%0d",
                   $time, act.x, act.y, act.pix, act.hs, act.vs, act.vo, act.vb, act.fc,
                   exp.x, exp.y, exp.pix, exp.hs, exp.vs, exp.vo, exp.vb, exp.fc);
      end
    end
    if (q_b.size() > 0) begin
      exp = q_b.pop_front();
      act = '{x: x_b, y: y_b, pix: pix_b, hs: hs_b, vs: vs_b, vo: vo_b, vb: vb_b, fc: frame_b};
      checks++;
      if (act !== exp) begin
        errors++;
        if (errors <= 20)
          $display("[TB] FAIL scoreboard_b t=%0t got x=%0d y=%0d pix=%b hs=%b vs=%b vo=%b vb=%b fc=%0d expected x=%0d y=%0d pix=%b hs=%b vs=%b vo=%b vb=%b fc=%0d",
                   $time, act.x, act.y, act.pix, act.hs, act.vs, act.vo, act.vb, act.fc,
                   exp.x, exp.y, exp.pix, exp.hs, exp.vs, exp.vo, exp.vb, exp.fc);
      end
    end
  end

  task automatic test_reset();
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({pix_a, x_a, y_a, hs_a, vs_a, vo_a, vb_a, frame_a} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
        errors++;
        $display("[TB] FAIL reset_values got pix=%b x=%0d y=%0d hs=%b vs=%b vo=%b vb=%b fc=%0d expected 0 0 0 1 1 0 0 0",
                 pix_a, x_a, y_a, hs_a, vs_a, vo_a, vb_a, frame_a);
      end
    end
    rst_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (pix_a !== ((k % 4) == 3)) begin
        errors++;
        $display("[TB] FAIL pix_clk_phase cycle=%0d got %b expected %b", k, pix_a, (k % 4) == 3);
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (x_a !== ((k == 4) ? 10'd1 : 10'd0)) begin
          errors++;
          $display("[TB] FAIL first_x cycle=%0d got %0d expected %0d", k, x_a, (k == 4) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_hsync();
    int low_cnt = 0, vo_cnt = 0, first_low = -1, last_low = -1;
    repeat (6500) begin
      @(negedge clk);
      if (pix_a && y_a == 10'd1) begin
        if (hs_a == 1'b0) begin
          low_cnt++;
          if (first_low < 0) first_low = int'(x_a);
          last_low = int'(x_a);
        end
        if (vo_a) vo_cnt++;
      end
    end
    checks++;
    if (low_cnt != 96) begin errors++; $display("[TB] FAIL hsync_width got %0d expected 96", low_cnt); end
    checks++;
    if (first_low != 657 || last_low != 752) begin
      errors++;
      $display("[TB] FAIL hsync_window got %0d..%0d expected 657..752", first_low, last_low);
    end
    checks++;
    if (vo_cnt != 640) begin errors++; $display("[TB] FAIL video_on_width got %0d expected 640", vo_cnt); end
  endtask

  task automatic test_wrap();
    int vs_cnt = 0, fx = -1, fy = -1, lx = -1, ly = -1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 2000 && !(x_b == 10'd23 && y_b == 10'd4); k++) @(negedge clk);
    checks++;
    if (!(x_b == 10'd23 && y_b == 10'd4)) begin errors++; $display("[TB] FAIL find_line_end got x=%0d y=%0d expected 23 4", x_b, y_b); end
    repeat (B_DIV) @(negedge clk);
    checks++;
    if (x_b !== 10'd0 || y_b !== 10'd5) begin errors++; $display("[TB] FAIL line_wrap got x=%0d y=%0d expected 0 5", x_b, y_b); end
    for (int k = 0; k < 2000 && !(x_b == 10'd23 && y_b == 10'd18); k++) @(negedge clk);
    checks++;
    if (!(x_b == 10'd23 && y_b == 10'd18)) begin errors++; $display("[TB] FAIL find_frame_end got x=%0d y=%0d expected 23 18", x_b, y_b); end
    repeat (B_DIV) @(negedge clk);
    checks++;
    if (x_b !== 10'd0 || y_b !== 10'd0) begin errors++; $display("[TB] FAIL frame_wrap got x=%0d y=%0d expected 0 0", x_b, y_b); end
    repeat (B_FRAME) begin
      @(negedge clk);
      if (pix_b && vs_b == 1'b0) begin
        vs_cnt++;
        if (fx < 0) begin fx = int'(x_b); fy = int'(y_b); end
        lx = int'(x_b); ly = int'(y_b);
      end
    end
    checks++;
    if (vs_cnt != 48 || fx != 2 || fy != 14 || lx != 1 || ly != 16) begin
      errors++;
      $display("[TB] FAIL vsync_window got cnt=%0d first=(%0d,%0d) last=(%0d,%0d) expected cnt=48 first=(2,14) last=(1,16)",
               vs_cnt, fx, fy, lx, ly);
    end
  endtask

  task automatic test_vblank();
    int pulses = 0;
    logic prev = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (3 * B_FRAME) begin
      @(negedge clk);
      if (vb_b) begin
        pulses++;
        checks++;
        if (x_b !== 10'd0 || y_b !== 10'd12 || prev !== 1'b0) begin
          errors++;
          $display("[TB] FAIL vblank_pulse got x=%0d y=%0d prev=%b expected x=0 y=12 prev=0", x_b, y_b, prev);
        end
      end
      prev = vb_b;
    end
    checks++;
    if (pulses != 3) begin errors++; $display("[TB] FAIL vblank_count got %0d expected 3", pulses); end
    checks++;
`ifdef VGA_FRAME_CNT_EN
    if (frame_b !== 16'd3) begin errors++; $display("[TB] FAIL frame_cnt got %0d expected 3", frame_b); end
`else
    if (frame_b !== 16'd0) begin errors++; $display("[TB] FAIL frame_cnt got %0d expected 0", frame_b); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 2000 && !(x_b == 10'd21 && y_b == 10'd15); k++) @(negedge clk);
    checks++;
    if (!(x_b == 10'd21 && y_b == 10'd15 && hs_b == 1'b0 && vs_b == 1'b0)) begin
      errors++;
      $display("[TB] FAIL mid_frame_setup got x=%0d y=%0d hs=%b vs=%b expected 21 15 0 0", x_b, y_b, hs_b, vs_b);
    end
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({x_b, y_b, hs_b, vs_b} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset got x=%0d y=%0d hs=%b vs=%b expected 0 0 1 1", x_b, y_b, hs_b, vs_b);
    end
    rst_b = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (x_b !== 10'd2 || y_b !== 10'd2) begin errors++; $display("[TB] FAIL scan_resume got x=%0d y=%0d expected 2 2", x_b, y_b); end
  endtask

  task automatic test_delay_align();
    for (int k = 0; k < 2000 && !(x_b == 10'd16 && y_b >= 10'd1 && y_b <= 10'd11); k++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (x_b !== 10'(16 + i) || vo_b !== (i < 2)) begin
        errors++;
        $display("[TB] FAIL delay_align step=%0d got x=%0d vo=%b expected x=%0d vo=%b", i, x_b, vo_b, 16 + i, i < 2);
      end
      repeat (B_DIV) @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] vga_timing bench start");
    test_reset();
    test_hsync();
    test_wrap();
    test_vblank();
    test_reset_mid_frame();
    test_delay_align();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-timing generator for the 640x480 @ 60 Hz display path. It divides the 100 MHz system clock into a 25 MHz pixel-enable strobe and scans horizontal/vertical counters. From these it produces the `x`/`y` coordinates, `pix_clk` enable, sync pulses and blanking flags consumed by the border, arrow and pixel-mixer stages. Every drawing stage downstream takes its coordinates from this block.

## Interface
- `DIV`, 4 — system clocks per pixel; legal range 2..16.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48 — horizontal segment lengths, in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33 — vertical segment lengths, in lines.
- `SYNC_POL`, 0 — active level of `hsync`/`vsync`; 0 = active-low.
- `DLY`, 1 — `pix_clk` periods by which `hsync`/`vsync`/`video_on` lag `x`/`y`; legal range 0..4.

Ports:
- `clk` in 1 — system clock, 100 MHz; the only clock.
- `rst` in 1 — synchronous, active-high reset.
- `pix_clk` out 1 — one-`clk`-wide enable strobe, once every `DIV` cycles; not a clock.
- `x` out 10 — horizontal count, 0..H_TOTAL-1.
- `y` out 10 — vertical count, 0..V_TOTAL-1.
- `hsync` out 1 — horizontal sync, delayed by `DLY`.
- `vsync` out 1 — vertical sync, delayed by `DLY`.
- `video_on` out 1 — high inside the 640x480 active area, delayed by `DLY`.
- `vblank_start` out 1 — one-`clk` pulse marking entry to vertical blanking.
- `frame_cnt` out 16 — frame counter (see Configuration).

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525 with default parameters.
- `div_cnt` counts 0..DIV-1 and wraps.
  - `pix_clk` = (`div_cnt` == DIV-1).
- On each `clk` edge where `pix_clk` = 1:
  - `x` increments.
  - `x` == H_TOTAL-1 wraps to 0 and advances `y`.
  - `y` == V_TOTAL-1 with `x` wrapping sends both to 0.
- Undelayed decodes:
  - `video_on` when `x` < H_ACTIVE and `y` < V_ACTIVE.
  - `hsync` active when `x` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - `vsync` active when `y` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- The decoded `hsync`/`vsync`/`video_on` pass through a `DLY`-stage shift register enabled by `pix_clk`.
  - This aligns them with downstream registered colour.
  - `DLY` = 0 means direct registered decode in phase with `x`/`y`.
- `vblank_start` is high in the `clk` cycle where `pix_clk` = 1, `x` == 0 and `y` == V_ACTIVE.
  - Game-state stages update arrow positions on this pulse.
- All outputs are registered, except `pix_clk`, which is a decode of the registered `div_cnt`.
- No counter may ever exceed its total. Counts are 10-bit unsigned, so H_TOTAL and V_TOTAL must each be ≤ 1024.

## Timing
- Reset values:
  - `div_cnt`, `x`, `y`, `frame_cnt` = 0.
  - `pix_clk` = 0 and `vblank_start` = 0.
  - `video_on` = 0.
  - `hsync` = `vsync` = inactive level (`~SYNC_POL`).
  - The delay-line contents reset to these same inactive values.
- After reset deasserts, the first `pix_clk` is at cycle DIV-1; `x` becomes 1 at cycle DIV.
- `x`/`y` are held stable for exactly `DIV` `clk` cycles.
  - A consumer that samples on `pix_clk` sees the current pixel, not the next one.
- Reset asserted mid-frame takes effect on the next `clk` edge, regardless of `pix_clk`. The scan restarts at (0,0) with no partial sync pulse.
- Line wrap and frame wrap both occur on the same `pix_clk` edge as the final increment; there is no dead cycle.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1 on each `vblank_start` and wraps 0xFFFF→0.
  - Used for scroll-speed and beat timing.
- `VGA_FRAME_CNT_EN` undefined:
  - `frame_cnt` is tied to 0 and no counter register is built.

## Structure
- Package `vga_pkg` holds:
  - the default timing constants;
  - H_TOTAL/V_TOTAL derivations;
  - coordinate width (10);
  - SYNC_POL default.
- Sub-module `sync_delay`: a parameterised `DLY`-deep, 3-bit-wide shift register with `pix_clk` enable, a reset value input and a `DLY` = 0 bypass.

## Test plan
- **Reset and divider:** hold `rst` for 5 cycles, then release.
  - All outputs take their reset values.
  - `pix_clk` pulses at cycles 3, 7, 11…
  - `x` = 1 at cycle 4.
- **Horizontal sync:** run one line.
  - `hsync` is low for exactly 96 pixels, from `x` = 656+DLY through 751+DLY.
  - `video_on` is high for 640 pixels.
- **Line and frame wrap:** at `x` = 799, `y` = 99 → next pixel is `x` = 0, `y` = 100.
  - At (799,524) → next pixel is (0,0).
  - `vsync` is low only for lines 490–491.
- **`vblank_start` / `frame_cnt`:** run 3 frames with `VGA_FRAME_CNT_EN` defined.
  - Exactly 3 single-`clk` pulses, each at `x` = 0, `y` = 480.
  - `frame_cnt` = 3.
  - With the macro undefined, `frame_cnt` stays 0.
- **Reset mid-frame:** assert `rst` at (700,491) with `vsync` active.
  - The next cycle shows (0,0) with `hsync`/`vsync` inactive.
  - The normal scan resumes.
- **Delay alignment:** with `DLY` = 2, `video_on` falls 2 `pix_clk` periods after `x` reaches 640.
